// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, FSM states,
// access-size decode and lane/misalignment helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} lsu_state_t;

    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} acc_size_t;

    // Stores only know SB/SH/SW; the unsigned load codes fall back to word for stores.
    function automatic acc_size_t access_size(input logic [2:0] f3, input logic we);
        if (f3 == F3_B || (!we && f3 == F3_BU)) begin
            return SzByte;
        end else if (f3 == F3_H || (!we && f3 == F3_HU)) begin
            return SzHalf;
        end else begin
            return SzWord;
        end
    endfunction

    // Byte lane of the access; offending low bits are dropped for half/word.
    function automatic logic [1:0] lane_offset(input acc_size_t size, input logic [1:0] addr_lo);
        case (size)
            SzByte:  return addr_lo;
            SzHalf:  return {addr_lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input acc_size_t size, input logic [1:0] addr_lo);
        return (size == SzHalf && addr_lo[0]) || (size == SzWord && addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data extraction: selects the addressed byte/half/word from a bus
// word and sign- or zero-extends it to 32 bits.
module load_formatter
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    acc_size_t   size;
    logic [31:0] shifted;

    always_comb begin
        size    = access_size(funct3, 1'b0);
        shifted = rdata >> {lane_offset(size, addr_lo), 3'b000};
        case (size)
            SzByte:  result = (funct3 == F3_BU) ? {24'b0, shifted[7:0]}
                                                : {{24{shifted[7]}}, shifted[7:0]};
            SzHalf:  result = (funct3 == F3_HU) ? {16'b0, shifted[15:0]}
                                                : {{16{shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: one byte/half/word access per instruction over a req/ready bus.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests skip the bus and pulse misalign.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_valid,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DATA_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [BE_W-1:0]       bus_be,
    input  logic                  bus_ready,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  misalign,
    output logic                  timeout
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    lsu_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  we_q, we_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  timed_out_q, timed_out_d;
    logic                  misal_q, misal_d;

    acc_size_t             size_q;
    logic [DATA_WIDTH-1:0] fmt_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
            misal_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            funct3_q    <= funct3_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
            misal_q     <= misal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        funct3_d    = funct3_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
        misal_d     = misal_q;
        case (state_q)
            StIdle: begin
                if (mem_read || mem_write) begin
                    addr_d      = addr;
                    wdata_d     = store_data;
                    funct3_d    = funct3;
                    we_d        = mem_write;
                    rdata_d     = '0;
                    cnt_d       = '0;
                    timed_out_d = 1'b0;
                    state_d     = StBusy;
`ifdef LSU_MISALIGN_TRAP_EN
                    misal_d = is_misaligned(access_size(funct3, mem_write), addr[1:0]);
                    if (misal_d) begin
                        state_d = StDone;
                    end
`else
                    misal_d = 1'b0;
`endif
                end
            end
            StBusy: begin
                if (bus_ready) begin
                    rdata_d = bus_rdata;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    // rdata_q stays cleared, so an abandoned load formats to 0
                    timed_out_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign size_q = access_size(funct3_q, we_q);

    load_formatter u_load_formatter (
        .funct3  (funct3_q),
        .addr_lo (addr_q[1:0]),
        .rdata   (rdata_q),
        .result  (fmt_data)
    );

    always_comb begin
        stall      = 1'b0;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_wdata  = '0;
        bus_be     = '0;
        load_valid = 1'b0;
        load_data  = '0;
        timeout    = 1'b0;
        misalign   = 1'b0;
        case (state_q)
            StIdle: stall = mem_read | mem_write;
            StBusy: begin
                stall    = 1'b1;
                bus_req  = 1'b1;
                bus_we   = we_q;
                bus_addr = {addr_q[DATA_WIDTH-1:2], 2'b00};
                case (size_q)
                    SzByte: begin
                        bus_be    = 4'b0001 << addr_q[1:0];
                        bus_wdata = {4{wdata_q[7:0]}};
                    end
                    SzHalf: begin
                        bus_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                        bus_wdata = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        bus_be    = 4'b1111;
                        bus_wdata = wdata_q;
                    end
                endcase
            end
            StDone: begin
                load_valid = !we_q && !misal_q;
                load_data  = load_valid ? fmt_data : '0;
                timeout    = timed_out_q;
                misalign   = misal_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses
// checked against a byte-lane arithmetic model of loads, stores and timeouts.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        misalign;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata),
        .misalign   (misalign),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ready_at: BUSY cycle (1-based) in which bus_ready is raised; 0 or >16 never completes.
    task automatic run_access(input logic we, input logic both, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ready_at, input logic [31:0] rd);
        int          sz;
        int          off;
        int          n;
        int          exp_n;
        logic        misal;
        logic        trapped;
        logic        sgn;
        logic        timed;
        logic [31:0] mask;
        logic [31:0] exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_ld;

        if (we) sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else    sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        sgn   = !we && (f3 == 3'd0 || f3 == 3'd1);
        misal = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
        trapped = misal;
`else
        trapped = 1'b0;
`endif
        off    = (sz == 1) ? int'(a % 4) : (sz == 2) ? int'(a % 4) / 2 * 2 : 0;
        mask   = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
        exp_be = ((32'd1 << sz) - 32'd1) << off;
        exp_wd = (sz == 1) ? (wd & 32'hFF) * 32'h0101_0101
               : (sz == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
        timed  = !trapped && !(ready_at >= 1 && ready_at <= 16);
        exp_n  = trapped ? 0 : timed ? 16 : ready_at;
        exp_ld = (rd >> (8 * off)) & mask;
        if (sgn && exp_ld[8 * sz - 1]) exp_ld = exp_ld | ~mask;
        if (timed || trapped || we) exp_ld = 32'h0;

        mem_write  = we;
        mem_read   = !we || both;
        funct3     = f3;
        addr       = a;
        store_data = wd;
        #1;
        check_eq("idle_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        n = 0;
        while (bus_req && n < 40) begin
            n++;
            check_eq("busy_stall", 32'(stall), 32'd1);
            check_eq("bus_addr", bus_addr, a & ~32'd3);
            check_eq("bus_we", 32'(bus_we), 32'(we));
            check_eq("bus_be", 32'(bus_be), exp_be);
            if (we) check_eq("bus_wdata", bus_wdata, exp_wd);
            bus_ready = (n == ready_at);
            bus_rdata = (n == ready_at) ? rd : $urandom;
            @(posedge clk);
            #1;
            bus_ready = 1'b0;
        end
        check_eq("busy_cycles", 32'(n), 32'(exp_n));
        check_eq("done_stall", 32'(stall), 32'd0);
        check_eq("load_valid", 32'(load_valid), 32'(!we && !trapped));
        check_eq("load_data", load_data, exp_ld);
        check_eq("timeout", 32'(timeout), 32'(timed));
        check_eq("misalign", 32'(misalign), 32'(trapped));
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_lv", 32'(load_valid), 32'd0);
        check_eq("idle_req", 32'(bus_req), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'd0;
        addr       = 32'h0;
        store_data = 32'h0;
        bus_ready  = 1'b0;
        bus_rdata  = 32'h0;
        #1;
        check_eq("rst_req", 32'(bus_req), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_lv", 32'(load_valid), 32'd0);
        check_eq("rst_ld", load_data, 32'd0);
        check_eq("rst_be", 32'(bus_be), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEAD_BEEF, 2, 32'h0);
        run_access(1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h8012_3456);
        run_access(1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 3, 32'h8012_3456);
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0000_ABCD, 1, 32'h0);
        run_access(1'b0, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h8001_FFFF);
        run_access(1'b0, 1'b0, 3'b010, 32'h200, 32'h0, 0, 32'h1234_5678);
        run_access(1'b0, 1'b0, 3'b010, 32'h101, 32'h0, 1, 32'hCAFE_F00D);
        run_access(1'b1, 1'b1, 3'b000, 32'h301, 32'h0000_00A5, 16, 32'h0);
        run_access(1'b0, 1'b0, 3'b101, 32'h303, 32'h0, 2, 32'h8765_4321);

        // Reset in the middle of a BUSY phase
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h400;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_eq("pre_rst_req", 32'(bus_req), 32'd1);
        rst      = 1'b1;
        mem_read = 1'b0;
        #1;
        check_eq("rst_busy_req", 32'(bus_req), 32'd0);
        check_eq("rst_busy_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_eq("post_rst_lv", 32'(load_valid), 32'd0);
            check_eq("post_rst_req", 32'(bus_req), 32'd0);
        end

        // Randomized accesses
        for (int i = 0; i < 80; i++) begin
            logic        we;
            logic [2:0]  f3;
            int          rdy;
            we  = 1'($urandom);
            f3  = 3'($urandom);
            rdy = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
            run_access(we, 1'($urandom), f3, $urandom, $urandom, rdy, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-memory stage directly downstream of the ALU.
- Takes the ALU SUM as the effective address and RD2 as store data.
- Runs one byte/half/word access per instruction over a simple req/ready bus.
- Returns sign- or zero-extended load data to the WD3 writeback mux.
- Stalls the PC and register-file write until the access completes.

Parameters:
DATA_WIDTH, 32, data and address width; only 32 is supported.
TIMEOUT_CYCLES, 16, maximum number of BUSY cycles waiting for bus_ready before the access is abandoned.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
mem_read  input  1  load request from control.
mem_write  input  1  store request from control; wins if asserted together with mem_read.
funct3  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW; other codes behave as word access.
addr  input  DATA_WIDTH  effective address (ALU SUM).
store_data  input  DATA_WIDTH  RD2 value.
stall  output  1  hold PC and block register write.
load_data  output  DATA_WIDTH  formatted load result.
load_valid  output  1  one-cycle pulse; load_data is valid in that cycle.
bus_req  output  1  bus request.
bus_we  output  1  1 = write.
bus_addr  output  DATA_WIDTH  word-aligned address, bits [1:0] = 0.
bus_wdata  output  DATA_WIDTH  lane-replicated store data.
bus_be  output  4  byte enables.
bus_ready  input  1  completion strobe; rdata is valid in the same cycle.
bus_rdata  input  DATA_WIDTH  read data.
misalign  output  1  one-cycle pulse on a misaligned access.
timeout  output  1  one-cycle pulse on bus timeout.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - All outputs and latched registers are 0.
  - Reset during BUSY drops bus_req in the same instant; no retry after reset.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall = mem_read | mem_write, combinational.
  - On a request, latch addr, funct3, store_data and we, then go to BUSY.
- BUSY:
  - bus_req = 1; bus_addr, bus_we, bus_be and bus_wdata are driven from the latches and held stable.
  - stall = 1.
  - A counter starts at 0 and increments each BUSY cycle.
  - bus_ready = 1: capture bus_rdata, go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without bus_ready: go to DONE, pulse timeout in the DONE cycle, load_data = 0.
- DONE:
  - stall = 0; load_valid = 1 for a load (0 for a store); load_data holds the formatted value.
  - Always return to IDLE.
  - mem_read/mem_write are ignored this cycle because the core advances on this edge.
- Minimum latency: request cycle plus one BUSY cycle (2 stalled cycles); the result appears in the 3rd cycle.
- Byte enables:
  - Byte: be = 1 << addr[1:0].
  - Half: be = 0011 if addr[1] = 0, else 1100.
  - Word: be = 1111.
- Store data: byte replicated into all 4 lanes, half replicated twice, word passed through.
- Load extraction: shift bus_rdata right by 8*addr[1:0], take 8/16/32 bits, then sign-extend (LB, LH) or zero-extend (LBU, LHU).
- Misaligned access: a half with addr[0] = 1, or a word with addr[1:0] != 0.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined:
  - A misaligned request in IDLE goes straight to DONE; no bus_req is issued.
  - misalign pulses for one cycle in DONE; load_data = 0; load_valid = 0.
- Undefined:
  - misalign is tied to 0.
  - The offending low address bits are ignored: a half access uses the half selected by addr[1], and a word access uses the aligned word.
  - The access proceeds normally.

Decomposition:
Package lsu_pkg:
- funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
- State enum lsu_state_t.
- Byte-enable width constant BE_W = 4.

Sub-module load_formatter:
- Combinational block: latched funct3, addr[1:0] and rdata in, extended 32-bit value out.
- Reused by the writeback path.

Test Plan:
1. SW addr 0x100, data 0xDEADBEEF, bus_ready asserted on the 2nd BUSY cycle -> bus_addr 0x100, be 1111, wdata 0xDEADBEEF, stall high for 3 cycles, load_valid stays 0.
2. LB addr 0x103, rdata 0x80123456 -> load_data 0xFFFFFF80; repeat as LBU -> 0x00000080; load_valid pulses for exactly 1 cycle.
3. SH addr 0x102, data 0x0000ABCD -> be 1100, wdata 0xABCDABCD; LH addr 0x102, rdata 0x8001FFFF -> load_data 0xFFFF8001.
4. LW with bus_ready held low -> bus_req high for 16 cycles, then timeout pulse, load_data 0, stall low, return to IDLE.
5. LW addr 0x101 -> with the macro: no bus_req, misalign pulse, 1 stall cycle. Without the macro: bus_addr 0x100, be 1111, misalign 0.
6. Assert rst during BUSY -> bus_req and stall drop immediately; after release an idle bus produces no spurious load_valid.
